// File: rtl/writeback_module_pkg.sv
// Shared constants for the writeback stage: control-bundle bit positions and
// the hard-wired zero register index.
package writeback_module_pkg;

  localparam int unsigned WB_BUNDLE_W  = 2;
  localparam int unsigned WB_REG_WRITE = 0;
  localparam int unsigned WB_LINK_SEL  = 1;
  localparam int unsigned REG_ZERO     = 0;

endpackage

// File: rtl/pipe_reg.sv
// Generic parameterised pipeline register with synchronous active-high clear
// and load enable.
// Ports: clk, reset (sync clear), en (load), d (next value), q (held value).
module pipe_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/writeback_module_reg_file_2r1w.sv
// Architectural register file: 2^AW x W, one synchronous write port, two
// asynchronous read ports with bypass of the pending write. Register 0 is
// hard-wired to zero on both write and read.
// Ports: clk, clear (sync clear of all entries), wr_en/wr_addr/wr_data (commit),
//        byp_en/byp_addr/byp_data (pending write visible to readers),
//        ra_addr/ra_data, rb_addr/rb_data (read ports).
module reg_file_2r1w
  import writeback_module_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          byp_en,
  input  logic [AW-1:0] byp_addr,
  input  logic [W-1:0]  byp_data,
  input  logic [AW-1:0] ra_addr,
  output logic [W-1:0]  ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [W-1:0]  rb_data
);

  localparam int unsigned NREG = 2 ** AW;

  logic [W-1:0] mem [NREG];
  logic         wr_ok;
  logic         byp_ok;

  assign wr_ok  = wr_en  && (wr_addr  != AW'(REG_ZERO));
  assign byp_ok = byp_en && (byp_addr != AW'(REG_ZERO));

  // Storage; clear has priority over a same-edge commit.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port A: zero register, then bypass, then storage.
  always_comb begin
    ra_data = mem[ra_addr];
    if (ra_addr == AW'(REG_ZERO)) begin
      ra_data = '0;
    end else if (byp_ok && (ra_addr == byp_addr)) begin
      ra_data = byp_data;
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rb_data = mem[rb_addr];
    if (rb_addr == AW'(REG_ZERO)) begin
      rb_data = '0;
    end else if (byp_ok && (rb_addr == byp_addr)) begin
      rb_data = byp_data;
    end
  end

endmodule

// File: rtl/writeback_module.sv
// Writeback pipeline stage: registers the memory-stage result, selects the
// writeback value, commits it to the register file, exposes a forwarding tap
// and counts retired instructions.
// Ports: clk, reset (sync, active-high), enable_in (advance), valid_in,
//        bundle_in, data_in, pc_seq_in, write_reg_in (stage inputs),
//        rs/rt_addr_in -> rs/rt_data_out (decode read ports),
//        fwd_valid_out/fwd_reg_out/fwd_data_out (pending write),
//        retired_count_out (retired valid instructions, wrapping).
module writeback_module
  import writeback_module_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_in,
  input  logic                   valid_in,
  input  logic [WB_BUNDLE_W-1:0] bundle_in,
  input  logic [W-1:0]           data_in,
  input  logic [W-1:0]           pc_seq_in,
  input  logic [AW-1:0]          write_reg_in,
  input  logic [AW-1:0]          rs_addr_in,
  input  logic [AW-1:0]          rt_addr_in,
  output logic [W-1:0]           rs_data_out,
  output logic [W-1:0]           rt_data_out,
  output logic                   fwd_valid_out,
  output logic [AW-1:0]          fwd_reg_out,
  output logic [W-1:0]           fwd_data_out,
  output logic [CNT_W-1:0]       retired_count_out
);

  localparam int unsigned STAGE_W = 1 + WB_BUNDLE_W + W + W + AW;

  logic [STAGE_W-1:0]     stage_d;
  logic [STAGE_W-1:0]     stage_q;
  logic                   valid_q;
  logic [WB_BUNDLE_W-1:0] bundle_q;
  logic [W-1:0]           data_q;
  logic [W-1:0]           pc_seq_q;
  logic [AW-1:0]          write_reg_q;
  logic [W-1:0]           wb_data;
  logic                   pending;
  logic                   wr;
  logic [CNT_W-1:0]       retired_q;

  // Stage registers hold while stalled.
  assign stage_d = {valid_in, bundle_in, data_in, pc_seq_in, write_reg_in};

  pipe_reg #(.W(STAGE_W)) u_stage (
    .clk   (clk),
    .reset (reset),
    .en    (enable_in),
    .d     (stage_d),
    .q     (stage_q)
  );

  assign {valid_q, bundle_q, data_q, pc_seq_q, write_reg_q} = stage_q;

  // Link writes return the sequential PC instead of the datapath result.
  assign wb_data = bundle_q[WB_LINK_SEL] ? pc_seq_q : data_q;
  assign pending = valid_q && bundle_q[WB_REG_WRITE] && (write_reg_q != AW'(REG_ZERO));
  assign wr      = pending && enable_in;

  reg_file_2r1w #(.W(W), .AW(AW)) u_rf (
    .clk      (clk),
    .clear    (reset),
    .wr_en    (wr),
    .wr_addr  (write_reg_q),
    .wr_data  (wb_data),
    .byp_en   (pending),
    .byp_addr (write_reg_q),
    .byp_data (wb_data),
    .ra_addr  (rs_addr_in),
    .ra_data  (rs_data_out),
    .rb_addr  (rt_addr_in),
    .rb_data  (rt_data_out)
  );

  assign fwd_valid_out = pending;
  assign fwd_reg_out   = write_reg_q;
  assign fwd_data_out  = wb_data;

  // Every valid instruction retires once, on the enabled edge that leaves the stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (enable_in && valid_q) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign retired_count_out = retired_q;

endmodule
